// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: control-bundle layout,
// depth limits and helpers used by the stage register slice.
package pipe_stage_reg_pkg;

    localparam int MAX_PIPE_DEPTH = 8;

    localparam int          CTRL_W_DEF = 8;
    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

    localparam int REGWRITE_BIT  = 0;
    localparam int MEMWRITE_BIT  = 1;
    localparam int RESULTSRC_LSB = 2;
    localparam int RESULTSRC_MSB = 3;

    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2
    } stage_act_e;

    function automatic logic [3:0] popcount(
        input logic [MAX_PIPE_DEPTH-1:0] bits
    );
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_PIPE_DEPTH; i++) begin
            n = n + {3'b000, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_cell.sv
// One pipeline stage: valid/data/ctrl with
// flush > stall > load priority and asynchronous reset.
module pipe_stage_cell
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    input  logic [CTRL_W-1:0] src_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl,
    output logic              valid_nxt
);

    stage_act_e act;

    // Pick this edge's action and the valid bit it will produce
    always_comb begin
        act       = ACT_LOAD;
        valid_nxt = src_valid;
        unique case (1'b1)
            flush: begin
                act       = ACT_FLUSH;
                valid_nxt = 1'b0;
            end
            (!flush && stall): begin
                act       = ACT_HOLD;
                valid_nxt = valid;
            end
            default: begin
                act       = ACT_LOAD;
                valid_nxt = src_valid;
            end
        endcase
    end

    // Stage registers; a bubble never carries control bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else begin
            valid <= valid_nxt;
            unique case (act)
                ACT_FLUSH: ctrl <= '0;
                ACT_LOAD: begin
                    data <= src_data;
                    ctrl <= src_valid ? src_ctrl : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// DEPTH-stage pipeline register with global stall, per-stage
// flush, registered occupancy and a saturating bubble counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic                       stall,
    input  logic [DEPTH-1:0]           flush,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           bubble_cnt
);

    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (DEPTH < 1 || DEPTH > MAX_PIPE_DEPTH) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH must be 1..8");
    end

    logic [DEPTH-1:0]             v;
    logic [DEPTH-1:0]             vn;
    logic [DEPTH-1:0][DATA_W-1:0] d;
    logic [DEPTH-1:0][CTRL_W-1:0] c;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic              sv;
        logic [DATA_W-1:0] sd;
        logic [CTRL_W-1:0] sc;

        if (k == 0) begin : g_head
            assign sv = in_valid;
            assign sd = in_data;
            assign sc = in_ctrl;
        end else begin : g_tail
            assign sv = v[k-1];
            assign sd = d[k-1];
            assign sc = c[k-1];
        end

        pipe_stage_cell #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush[k]),
            .stall     (stall),
            .src_valid (sv),
            .src_data  (sd),
            .src_ctrl  (sc),
            .valid     (v[k]),
            .data      (d[k]),
            .ctrl      (c[k]),
            .valid_nxt (vn[k])
        );
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign out_ctrl  = c[DEPTH-1];

    // Occupancy tracks the valid bits on the same edge they change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= OCC_W'(popcount(MAX_PIPE_DEPTH'(vn)));
        end
    end

    // Count edges seen with an empty output stage, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!out_valid && bubble_cnt != CNT_MAX) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule
